slave_stream_bridge: RTL

SLAVE_STREAM_BRIDGE -- requirements
Module: slave_stream_bridge

---
 rtl/slave_stream_bridge.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/slave_stream_bridge.sv
// slave_stream_bridge
// Bridges a simple req/ack register bus (cross_bar slave port) to a pair of
// valid/ready streams through two DEPTH-entry FIFOs.
//   clk_i, reset_i        : single clock, synchronous active-high reset
//   req_i, addr_i, cmd_i  : bus request, byte address (addr[3:0] decoded),
//   wdata_i               : 1 = write / 0 = read, write data
//   ack_o, rdata_o        : one-cycle acceptance pulse, registered read data
//   tx_valid_o/tx_ready_i/tx_data_o : outbound stream (TX FIFO head)
//   rx_valid_i/rx_ready_o/rx_data_i : inbound stream (RX FIFO tail)
// Map: 0x0 DATA (wr = TX push, rd = RX pop), 0x4 STATUS (ro), 0x8 CONTROL (wo,
// bit0 flushes TX, bit1 flushes RX).
module slave_stream_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              cmd_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic [DATA_W-1:0] rx_data_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  typedef enum logic [1:0] {IDLE, ACK, RESP} state_t;

  state_t state_q, state_d;

  logic [3:0]        opOffset_q;
  logic              opWrite_q;
  logic [DATA_W-1:0] opWdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] txMem [DEPTH];
  logic [DATA_W-1:0] rxMem [DEPTH];
  logic [PTR_W-1:0]  txWr_q, txWr_d, txRd_q, txRd_d;
  logic [PTR_W-1:0]  rxWr_q, rxWr_d, rxRd_q, rxRd_d;
  logic [CNT_W-1:0]  txCount_q, txCount_d, rxCount_q, rxCount_d;

  logic [ADDR_W-5:0] unusedAddrBits;
  logic [3:0]  reqOffset;
  logic        txEmpty, txFull, rxEmpty, rxFull;
  logic        accept, inAck;
  logic        busPush, busPop, flushTx, flushRx, txPop, rxPush;
  logic [31:0] status;

  assign unusedAddrBits = addr_i[ADDR_W-1:4];
  assign reqOffset      = addr_i[3:0];

  assign txEmpty = (txCount_q == '0);
  assign txFull  = (txCount_q == FULL_CNT);
  assign rxEmpty = (rxCount_q == '0);
  assign rxFull  = (rxCount_q == FULL_CNT);

  // A DATA access that would overflow TX or underflow RX waits in IDLE.
  assign accept = !((reqOffset == OFF_DATA) && cmd_i && txFull) &&
                  !((reqOffset == OFF_DATA) && !cmd_i && rxEmpty);

  // The request is latched on entry to ACK, so the master may drop req as
  // soon as it sees ack without disturbing the operation in flight.
  assign inAck   = (state_q == ACK);
  assign busPush = inAck && opWrite_q && (opOffset_q == OFF_DATA);
  assign busPop  = inAck && !opWrite_q && (opOffset_q == OFF_DATA);
  assign flushTx = inAck && opWrite_q && (opOffset_q == OFF_CTRL) && opWdata_q[0];
  assign flushRx = inAck && opWrite_q && (opOffset_q == OFF_CTRL) && opWdata_q[1];

  assign tx_valid_o = !txEmpty && !reset_i;
  assign tx_data_o  = txMem[txRd_q];
  assign rx_ready_o = !rxFull && !reset_i;
  assign txPop      = tx_valid_o && tx_ready_i;
  assign rxPush     = rx_valid_i && rx_ready_o;

  // Outputs are forced inactive combinationally so a reset asserted during
  // ACK suppresses the pulse in that same cycle.
  assign ack_o   = inAck && !reset_i;
  assign rdata_o = reset_i ? '0 : rdata_q;

  assign status = {8'h00, 8'(rxCount_q), 8'(txCount_q), 4'h0,
                   rxFull, rxEmpty, txFull, txEmpty};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i && accept) state_d = ACK;
      ACK:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (inAck && !opWrite_q) begin
      case (opOffset_q)
        OFF_DATA:   rdata_d = rxMem[rxRd_q];
        OFF_STATUS: rdata_d = DATA_W'(status);
        default:    rdata_d = '0;
      endcase
    end
  end

  // Flush takes priority over any stream transfer on the same FIFO.
  always_comb begin
    txWr_d    = txWr_q;
    txRd_d    = txRd_q;
    txCount_d = txCount_q;
    if (flushTx) begin
      txWr_d    = '0;
      txRd_d    = '0;
      txCount_d = '0;
    end else begin
      if (busPush) txWr_d = txWr_q + PTR_ONE;
      if (txPop)   txRd_d = txRd_q + PTR_ONE;
      if (busPush && !txPop)      txCount_d = txCount_q + CNT_ONE;
      else if (!busPush && txPop) txCount_d = txCount_q - CNT_ONE;
    end
  end

  always_comb begin
    rxWr_d    = rxWr_q;
    rxRd_d    = rxRd_q;
    rxCount_d = rxCount_q;
    if (flushRx) begin
      rxWr_d    = '0;
      rxRd_d    = '0;
      rxCount_d = '0;
    end else begin
      if (rxPush) rxWr_d = rxWr_q + PTR_ONE;
      if (busPop) rxRd_d = rxRd_q + PTR_ONE;
      if (rxPush && !busPop)      rxCount_d = rxCount_q + CNT_ONE;
      else if (!rxPush && busPop) rxCount_d = rxCount_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      opOffset_q <= '0;
      opWrite_q  <= 1'b0;
      opWdata_q  <= '0;
      rdata_q    <= '0;
      txWr_q     <= '0;
      txRd_q     <= '0;
      txCount_q  <= '0;
      rxWr_q     <= '0;
      rxRd_q     <= '0;
      rxCount_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        opOffset_q <= reqOffset;
        opWrite_q  <= cmd_i;
        opWdata_q  <= wdata_i;
      end
      rdata_q   <= rdata_d;
      txWr_q    <= txWr_d;
      txRd_q    <= txRd_d;
      txCount_q <= txCount_d;
      rxWr_q    <= rxWr_d;
      rxRd_q    <= rxRd_d;
      rxCount_q <= rxCount_d;
    end
  end

  // Storage is not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk_i) begin
    if (busPush) txMem[txWr_q] <= opWdata_q;
    if (rxPush)  rxMem[rxWr_q] <= rx_data_i;
  end

endmodule
